// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and sizing helpers for the nibble-serial adder.
package nsa_pkg;

  localparam int unsigned NIBBLE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int unsigned nib_count(input int unsigned width);
    return width / NIBBLE;
  endfunction

  // Nibble index width; never narrower than one bit so WIDTH=4 still builds.
  function automatic int unsigned idx_width(input int unsigned width);
    int unsigned n;
    n = width / NIBBLE;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle; ovf exists only when NSA_OVERFLOW_EN is defined.
interface nibble_serial_adder_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef NSA_OVERFLOW_EN
  logic             ovf;

  modport master (output in_valid, a, b, cin, out_ready,
                  input  in_ready, out_valid, sum, cout, ovf);
  modport slave  (input  in_valid, a, b, cin, out_ready,
                  output in_ready, out_valid, sum, cout, ovf);
`else
  modport master (output in_valid, a, b, cin, out_ready,
                  input  in_ready, out_valid, sum, cout);
  modport slave  (input  in_valid, a, b, cin, out_ready,
                  output in_ready, out_valid, sum, cout);
`endif
endinterface

// File: rtl/nibble_serial_adder_clb.sv
// 4-bit carry look-ahead adder, reused once per nibble by the serial adder.
module CLB
  import nsa_pkg::*;
(
  input  logic [NIBBLE-1:0] a,
  input  logic [NIBBLE-1:0] b,
  input  logic              cin,
  output logic [NIBBLE-1:0] sum,
  output logic              cout
);
  logic [NIBBLE-1:0] g;
  logic [NIBBLE-1:0] p;
  logic [NIBBLE:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Flattened look-ahead carries, no ripple through c[]
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = p ^ c[NIBBLE-1:0];
  assign cout = c[NIBBLE];
endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that runs one CLB over the operand nibbles, LSB nibble first.
// Optional signed-overflow output enabled by defining NSA_OVERFLOW_EN.
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  nibble_serial_adder_if.slave bus
);
  localparam int unsigned        N        = nib_count(WIDTH);
  localparam int unsigned        IDX_W    = idx_width(WIDTH);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(N - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
`ifdef NSA_OVERFLOW_EN
  logic               ovf_q, ovf_d;
`endif

  logic [NIBBLE-1:0]  nib_a_c;
  logic [NIBBLE-1:0]  nib_b_c;
  logic [NIBBLE-1:0]  nib_sum_c;
  logic               nib_cout_c;

  assign nib_a_c = a_q[NIBBLE*idx_q +: NIBBLE];
  assign nib_b_c = b_q[NIBBLE*idx_q +: NIBBLE];

  CLB u_clb (
    .a    (nib_a_c),
    .b    (nib_b_c),
    .cin  (carry_q),
    .sum  (nib_sum_c),
    .cout (nib_cout_c)
  );

  // Next-state and datapath updates
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
`ifdef NSA_OVERFLOW_EN
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
`ifdef NSA_OVERFLOW_EN
          ovf_d   = 1'b0;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[NIBBLE*idx_q +: NIBBLE] = nib_sum_c;
        carry_d = nib_cout_c;
        if (idx_q == LAST_IDX) begin
          cout_d  = nib_cout_c;
`ifdef NSA_OVERFLOW_EN
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (nib_sum_c[NIBBLE-1] != a_q[WIDTH-1]);
`endif
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef NSA_OVERFLOW_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef NSA_OVERFLOW_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
`ifdef NSA_OVERFLOW_EN
  assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder at WIDTH=16 and WIDTH=4; ovf checked when NSA_OVERFLOW_EN is defined.
module tb_nibble_serial_adder;

  localparam int NRAND = 1000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nibble_serial_adder_if #(.WIDTH(16)) bus16 ();
  nibble_serial_adder_if #(.WIDTH(4))  bus4 ();

  nibble_serial_adder #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));
  nibble_serial_adder #(.WIDTH(4))  u_dut4  (.clk(clk), .rst(rst), .bus(bus4));

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  typedef struct {
    logic [16:0] total;
    logic        ov;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference result from plain integer arithmetic
  function automatic exp_t model16(input logic [15:0] a, input logic [15:0] b, input logic cin);
    exp_t e;
    int   sa, sb, ssum;
    e.total = 17'(a) + 17'(b) + 17'(cin);
    sa      = int'($signed(a));
    sb      = int'($signed(b));
    ssum    = sa + sb + (cin ? 1 : 0);
    e.ov    = (ssum > 32767) || (ssum < -32768);
    return e;
  endfunction

  task automatic txn16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                       output logic [15:0] s, output logic co, output logic ov, output int lat);
    int guard;
    guard = 0;
    while (!bus16.in_ready && guard < 20) begin
      tick();
      guard++;
    end
    if (!bus16.in_ready) check("txn16_ready_timeout", 32'd0, 32'd1);
    bus16.a        = a;
    bus16.b        = b;
    bus16.cin      = cin;
    bus16.in_valid = 1'b1;
    tick();
    bus16.in_valid = 1'b0;
    lat = 0;
    while (!bus16.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    s  = bus16.sum;
    co = bus16.cout;
`ifdef NSA_OVERFLOW_EN
    ov = bus16.ovf;
`else
    ov = 1'b0;
`endif
    bus16.out_ready = 1'b1;
    tick();
    bus16.out_ready = 1'b0;
  endtask

  initial begin
    vec_t        vecs [6];
    logic [15:0] s;
    logic        co, ov;
    int          lat;

    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[4] = '{16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[5] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};

    rst = 1'b1;
    bus16.in_valid = 1'b0; bus16.out_ready = 1'b0;
    bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0;
    bus4.in_valid  = 1'b0; bus4.out_ready  = 1'b0;
    bus4.a  = '0; bus4.b  = '0; bus4.cin  = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    check("rst_in_ready",  32'(bus16.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus16.out_valid), 32'd0);
    check("rst_sum",       32'(bus16.sum),       32'd0);
    check("rst_cout",      32'(bus16.cout),      32'd0);
    check("rst4_in_ready", 32'(bus4.in_ready),   32'd1);
`ifdef NSA_OVERFLOW_EN
    check("rst_ovf",       32'(bus16.ovf),       32'd0);
`endif

    // Directed table
    for (int i = 0; i < 6; i++) begin
      txn16(vecs[i].a, vecs[i].b, vecs[i].cin, s, co, ov, lat);
      check($sformatf("vec%0d_sum", i),  32'(s),   32'(vecs[i].s));
      check($sformatf("vec%0d_cout", i), 32'(co),  32'(vecs[i].co));
      check($sformatf("vec%0d_lat", i),  32'(lat), 32'd4);
`ifdef NSA_OVERFLOW_EN
      check($sformatf("vec%0d_ovf", i),  32'(ov),  32'(vecs[i].ov));
`endif
    end

    // Backpressure in DONE with a new pair offered throughout
    bus16.a = 16'h1111; bus16.b = 16'h2222; bus16.cin = 1'b0;
    bus16.in_valid = 1'b1;
    tick();
    bus16.in_valid = 1'b0;
    lat = 0;
    while (!bus16.out_valid && lat < 20) begin tick(); lat++; end
    check("bp_first_lat", 32'(lat), 32'd4);
    bus16.a = 16'hAAAA; bus16.b = 16'h5555; bus16.cin = 1'b1;
    bus16.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("bp_sum",       32'(bus16.sum),       32'h3333);
      check("bp_cout",      32'(bus16.cout),      32'd0);
      check("bp_in_ready",  32'(bus16.in_ready),  32'd0);
      check("bp_out_valid", 32'(bus16.out_valid), 32'd1);
      tick();
    end
    bus16.out_ready = 1'b1;
    tick();
    bus16.out_ready = 1'b0;
    check("bp_idle_out_valid", 32'(bus16.out_valid), 32'd0);
    check("bp_idle_in_ready",  32'(bus16.in_ready),  32'd1);
    tick();
    bus16.in_valid = 1'b0;
    lat = 0;
    while (!bus16.out_valid && lat < 20) begin tick(); lat++; end
    check("bp_second_lat",  32'(lat),        32'd4);
    check("bp_second_sum",  32'(bus16.sum),  32'h0000);
    check("bp_second_cout", 32'(bus16.cout), 32'd1);
    bus16.out_ready = 1'b1;
    tick();
    bus16.out_ready = 1'b0;

    // Reset two cycles into RUN
    bus16.a = 16'hABCD; bus16.b = 16'h1111; bus16.cin = 1'b0;
    bus16.in_valid = 1'b1;
    tick();
    bus16.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_in_ready",  32'(bus16.in_ready),  32'd1);
    check("mrst_out_valid", 32'(bus16.out_valid), 32'd0);
    check("mrst_sum",       32'(bus16.sum),       32'd0);
    check("mrst_cout",      32'(bus16.cout),      32'd0);
    repeat (5) begin
      tick();
      check("mrst_no_result", 32'(bus16.out_valid), 32'd0);
    end
    txn16(16'h0F0F, 16'hF0F0, 1'b1, s, co, ov, lat);
    check("mrst_after_sum",  32'(s),  32'h0000);
    check("mrst_after_cout", 32'(co), 32'd1);

    // WIDTH=4: single-nibble operation
    for (int i = 0; i < 9; i++) begin
      logic [3:0] a4, b4;
      logic       c4;
      logic [4:0] e4;
      int         l4;
      if (i == 0) begin
        a4 = 4'hF; b4 = 4'hF; c4 = 1'b1;
      end else begin
        a4 = 4'($urandom); b4 = 4'($urandom); c4 = 1'($urandom);
      end
      e4 = 5'(a4) + 5'(b4) + 5'(c4);
      bus4.a = a4; bus4.b = b4; bus4.cin = c4;
      bus4.in_valid = 1'b1;
      tick();
      bus4.in_valid = 1'b0;
      l4 = 0;
      while (!bus4.out_valid && l4 < 10) begin tick(); l4++; end
      check("w4_lat",  32'(l4),        32'd1);
      check("w4_sum",  32'(bus4.sum),  32'(e4[3:0]));
      check("w4_cout", 32'(bus4.cout), 32'(e4[4]));
      bus4.out_ready = 1'b1;
      tick();
      bus4.out_ready = 1'b0;
    end

    // Random sweep: independent producer and consumer with random gaps
    begin
      int got;
      got = 0;
      fork
        begin
          for (int i = 0; i < NRAND; i++) begin
            int          gap, wc;
            logic        acc, rdy;
            logic [15:0] ra, rb;
            logic        rc;
            gap = int'($urandom_range(0, 3));
            repeat (gap) tick();
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            bus16.a = ra; bus16.b = rb; bus16.cin = rc;
            bus16.in_valid = 1'b1;
            acc = 1'b0; wc = 0;
            while (!acc && wc < 60) begin
              rdy = bus16.in_ready;
              tick();
              wc++;
              if (rdy) acc = 1'b1;
            end
            bus16.in_valid = 1'b0;
            if (!acc) begin
              check("rand_accept_timeout", 32'd0, 32'd1);
              break;
            end
            q.push_back(model16(ra, rb, rc));
          end
        end
        begin
          int   cyc;
          logic rr, ov_s, c_s, o_s;
          logic [15:0] s_s;
          exp_t e;
          cyc = 0;
          while (got < NRAND && cyc < 40000) begin
            rr = 1'($urandom_range(0, 1));
            bus16.out_ready = rr;
            ov_s = bus16.out_valid;
            s_s  = bus16.sum;
            c_s  = bus16.cout;
`ifdef NSA_OVERFLOW_EN
            o_s  = bus16.ovf;
`else
            o_s  = 1'b0;
`endif
            tick();
            cyc++;
            if (ov_s && rr) begin
              if (q.size() == 0) begin
                check("rand_duplicate", 32'd1, 32'd0);
              end else begin
                e = q.pop_front();
                check("rand_sum", 32'({c_s, s_s}), 32'(e.total));
`ifdef NSA_OVERFLOW_EN
                check("rand_ovf", 32'(o_s), 32'(e.ov));
`endif
                got++;
              end
            end
          end
          bus16.out_ready = 1'b0;
          if (o_s === 1'bx) check("rand_ovf_x", 32'd1, 32'd0);
        end
      join
      check("rand_count",       32'(got),      32'(NRAND));
      check("rand_queue_empty", 32'(q.size()), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle wide-operand adder that time-multiplexes the team's existing 4-bit carry look-ahead adder (`CLB`) across the nibbles of a WIDTH-bit operand pair, one nibble per clock. It accepts an operand pair through a valid/ready handshake and feeds `CLB` least-significant nibble first. The carry-out of each nibble is registered as the carry-in of the next. The block presents the assembled sum and final carry through a second valid/ready handshake to the downstream consumer.

## Interface
- WIDTH, 16, operand/sum width; must be a multiple of 4, minimum 4; N = WIDTH/4 nibbles
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands (high only in IDLE)
- a  in  WIDTH  operand A, sampled on accept
- b  in  WIDTH  operand B, sampled on accept
- cin  in  1  carry-in to nibble 0, sampled on accept
- out_valid  out  1  result valid (high only in DONE)
- out_ready  in  1  consumer takes result
- sum  out  WIDTH  registered sum
- cout  out  1  registered carry-out of nibble N-1
- ovf  out  1  signed overflow (only with NSA_OVERFLOW_EN)

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: latch a, b, cin into internal registers; idx<=0; carry<=cin; clear sum; go to RUN.
- RUN:
  - Drive `CLB` with a_r[4*idx+:4], b_r[4*idx+:4] and carry.
  - At each edge, write the `CLB` sum into sum[4*idx+:4] and set carry<=`CLB` cout.
  - If idx==N-1: cout<=`CLB` cout and go to DONE. Otherwise idx<=idx+1.
- DONE:
  - out_valid=1.
  - sum, cout and ovf are held stable until out_ready.
  - On out_ready, go to IDLE.
- in_valid is ignored outside IDLE. Operands are never re-sampled mid-operation, so upstream may change a and b freely after the accept.
- No same-cycle hand-off: the DONE→IDLE transition occupies one edge, and in_ready rises the cycle after the result is taken.
- Arithmetic is unsigned modulo 2^WIDTH; cout is bit WIDTH of a+b+cin.
- Reset mid-operation (any state) abandons the operation. The next state is IDLE with all registers cleared and no partial result emitted.

## Timing
- Reset values: in_ready=1 (IDLE), out_valid=0, sum=0, cout=0, ovf=0, idx=0, carry=0.
- Accept at edge E0. Nibble k is written at edge E(k+1). out_valid rises after edge EN, giving a latency of N cycles (4 for WIDTH=16).
- Minimum initiation interval is N+2 cycles (accept, N RUN cycles, DONE with out_ready=1). The IDLE cycle overlaps the next accept.
- in_ready and out_valid are decoded from registered state only; there are no combinational paths from inputs to outputs.
- The critical path is one `CLB` instance plus the nibble mux.

## Configuration
- NSA_OVERFLOW_EN defined:
  - ovf port present.
  - Registered at the final RUN edge as (a_r[MSB]==b_r[MSB]) && (sum_new[MSB]!=a_r[MSB]).
  - Cleared on reset and on accept; held through DONE.
- NSA_OVERFLOW_EN undefined:
  - ovf port and its logic are absent.
  - All other behaviour is identical.

## Structure
- Package nsa_pkg:
  - state enum (IDLE, RUN, DONE)
  - NIBBLE=4 constant
  - helper function for N and the idx width ($clog2(N), minimum 1)
- One sub-module: a single `CLB` instance (ports a, b, cin, sum, cout), reused every RUN cycle. There is no per-nibble replication.

## Test plan
- WIDTH=16, a=16'hFFFF, b=16'h0001, cin=0 → sum=16'h0000, cout=1, ovf=0; out_valid exactly 4 cycles after the accept edge.
- a=16'h1234, b=16'h4321, cin=1 → sum=16'h5556, cout=0. a=16'h7FFF, b=16'h0001 → sum=16'h8000, cout=0, ovf=1 (NSA_OVERFLOW_EN).
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles in DONE, with in_valid=1 and new operands driven throughout.
  - Response: sum/cout stable, in_ready=0, no second accept; after out_ready=1, in_ready=1 one cycle later and the second pair then completes correctly.
- Reset mid-operation:
  - Stimulus: assert rst 2 cycles into RUN with a=16'hABCD, b=16'h1111.
  - Response: the next cycle shows in_ready=1, out_valid=0, sum=0, cout=0; a subsequent a=16'h0F0F, b=16'hF0F0, cin=1 → sum=16'h0000, cout=1.
- WIDTH=4, a=4'hF, b=4'hF, cin=1 → sum=4'hF, cout=1, latency 1 cycle.
- Random sweep: 1000 random a/b/cin at WIDTH=16 with random in_valid/out_ready gaps → every result matches a+b+cin, with no dropped or duplicated transactions.
